mult4_axi_job_master: RTL

AXI4-Lite master that sits directly upstream of the 4-bit multiplier AXI4 register slave and turns a valid/ready stream of operand pairs into register-level transactions. For each job it does the following in order: write operands, assert start, poll done, read the result, clear start, wait for done to drop. It then presents the 8-bit result on a valid/ready output stream. It lets a datapath use the memristor multiplier without a CPU.

---
 rtl/mult4_axi_job_master.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mult4_axi_job_master.sv
// rtl/mult4_axi_job_master.sv - AXI4-Lite master that runs 4-bit multiply jobs on the multiplier register slave
//
// Purpose:
//   Accepts operand pairs on a valid/ready stream. For each job it writes the
//   operands, sets start, polls done, reads the result, clears start and waits
//   for done to drop. It then presents the 8-bit product on a valid/ready
//   result stream. At most one AXI transaction is outstanding at any time.
//
// Ports:
//   ACLK, ARESETn                          clock, asynchronous active-low reset
//   op_valid, op_ready, op_a, op_b         job input stream
//   res_valid, res_ready, res_data, res_err  result output stream
//   busy                                   a job is in progress
//   AW*, W*, B*                            AXI4-Lite write channels
//   AR*, R*                                AXI4-Lite read channels
module mult4_axi_job_master #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          POLL_TIMEOUT = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_a,
  input  logic [3:0]  op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_err,
  output logic        busy,
  output logic [31:0] AWADDR,
  output logic [2:0]  AWPROT,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic [31:0] ARADDR,
  output logic [2:0]  ARPROT,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY
);

  localparam int CW = $clog2(POLL_TIMEOUT + 1);

  localparam logic [31:0] OFF_CONTROL      = 32'h00;
  localparam logic [31:0] OFF_STATUS       = 32'h04;
  localparam logic [31:0] OFF_MULTIPLIER   = 32'h08;
  localparam logic [31:0] OFF_MULTIPLICAND = 32'h0C;
  localparam logic [31:0] OFF_RESULT       = 32'h10;

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_GO, POLL_DONE, RD_RES, WR_CLR, POLL_CLR, OUT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    b_q, b_d;
  logic          err_q, err_d;
  logic [7:0]    res_q, res_d;
  logic          res_valid_q, res_valid_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [31:0]   awaddr_q, awaddr_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          wr_done, rd_done, rd_err, poll_expired;
  logic          launch_wr, launch_rd;
  logic [31:0]   launch_off, launch_data;

  // Only the low byte of read data carries status/result information.
  logic unused_rdata;
  assign unused_rdata = ^RDATA[31:8];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      b_q         <= '0;
      err_q       <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= BASE_ADDR;
      araddr_q    <= BASE_ADDR;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      err_q       <= err_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    err_d       = err_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    launch_wr   = 1'b0;
    launch_rd   = 1'b0;
    launch_off  = '0;
    launch_data = '0;

    cnt_inc      = cnt_q + CW'(1);
    poll_expired = (cnt_inc == CW'(POLL_TIMEOUT));
    wr_done      = bready_q && BVALID;
    rd_done      = rready_q && RVALID;
    rd_err       = rd_done && (RRESP != 2'b00);

    // AW and W drop independently once their own handshake has happened.
    if (awvalid_q && AWREADY) awvalid_d = 1'b0;
    if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
    if (arvalid_q && ARREADY) arvalid_d = 1'b0;
    if (wr_done) begin
      bready_d = 1'b0;
      if (BRESP != 2'b00) err_d = 1'b1;
    end
    if (rd_done) begin
      rready_d = 1'b0;
      if (rd_err) err_d = 1'b1;
    end

    // The next transaction is launched on the same edge that completes the
    // current one, so a zero-wait slave sees back-to-back 2-cycle transfers.
    unique case (state_q)
      IDLE: begin
        if (op_valid && op_ready) begin
          b_d         = op_b;
          err_d       = 1'b0;
          state_d     = WR_A;
          launch_wr   = 1'b1;
          launch_off  = OFF_MULTIPLIER;
          launch_data = {28'h0, op_a};
        end
      end
      WR_A: begin
        if (wr_done) begin
          state_d     = WR_B;
          launch_wr   = 1'b1;
          launch_off  = OFF_MULTIPLICAND;
          launch_data = {28'h0, b_q};
        end
      end
      WR_B: begin
        if (wr_done) begin
          state_d     = WR_GO;
          launch_wr   = 1'b1;
          launch_off  = OFF_CONTROL;
          launch_data = 32'h1;
        end
      end
      WR_GO: begin
        if (wr_done) begin
          state_d    = POLL_DONE;
          cnt_d      = '0;
          launch_rd  = 1'b1;
          launch_off = OFF_STATUS;
        end
      end
      POLL_DONE: begin
        if (rd_done) begin
          // An error response counts as done so the job can wind down.
          if (rd_err || RDATA[0]) begin
            state_d    = RD_RES;
            launch_rd  = 1'b1;
            launch_off = OFF_RESULT;
          end else if (poll_expired) begin
            err_d       = 1'b1;
            res_d       = '0;
            state_d     = WR_CLR;
            launch_wr   = 1'b1;
            launch_off  = OFF_CONTROL;
            launch_data = '0;
          end else begin
            cnt_d      = cnt_inc;
            launch_rd  = 1'b1;
            launch_off = OFF_STATUS;
          end
        end
      end
      RD_RES: begin
        if (rd_done) begin
          res_d       = rd_err ? 8'h00 : RDATA[7:0];
          state_d     = WR_CLR;
          launch_wr   = 1'b1;
          launch_off  = OFF_CONTROL;
          launch_data = '0;
        end
      end
      WR_CLR: begin
        if (wr_done) begin
          state_d    = POLL_CLR;
          cnt_d      = '0;
          launch_rd  = 1'b1;
          launch_off = OFF_STATUS;
        end
      end
      POLL_CLR: begin
        if (rd_done) begin
          // An error response counts as done=0 here.
          if (rd_err || !RDATA[0]) begin
            state_d     = OUT;
            res_valid_d = 1'b1;
          end else if (poll_expired) begin
            err_d       = 1'b1;
            state_d     = OUT;
            res_valid_d = 1'b1;
          end else begin
            cnt_d      = cnt_inc;
            launch_rd  = 1'b1;
            launch_off = OFF_STATUS;
          end
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch_wr) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      bready_d  = 1'b1;
      awaddr_d  = BASE_ADDR + launch_off;
      wdata_d   = launch_data;
    end
    if (launch_rd) begin
      arvalid_d = 1'b1;
      rready_d  = 1'b1;
      araddr_d  = BASE_ADDR + launch_off;
    end
  end

  // op_ready is gated by reset so it reads low while ARESETn is asserted.
  assign op_ready  = ARESETn && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign res_err   = err_q;
  assign AWADDR    = awaddr_q;
  assign AWPROT    = 3'b000;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = 4'hF;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARPROT    = 3'b000;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule
